// File: rtl/mem_copy_if.sv
// Request and memory-port bundle for mem_copy_engine.
// The master is the requester plus the 1RW memory; the slave is the engine.
interface mem_copy_if #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
);
    logic              start_v;
    logic              start_ready;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              mem_v;
    logic              mem_w;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output start_v, src, dst, len, mem_rdata,
        input  start_ready, busy, done, mem_v, mem_w, mem_addr, mem_wdata
    );

    modport slave (
        input  start_v, src, dst, len, mem_rdata,
        output start_ready, busy, done, mem_v, mem_w, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word forward memory copy over a single 1RW port with one-cycle read latency.
// Each word takes a READ cycle then a WRITE cycle; read data is passed straight to write data.
module mem_copy_engine #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
) (
    input logic       clk_i,
    input logic       reset_n_i,
    mem_copy_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    localparam logic [ADDR_W-1:0] PtrOne = 1;
    localparam logic [ADDR_W:0]   CntOne = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start_v) state_d = (bus.len != '0) ? StRead : StDone;
            StRead:  state_d = StWrite;
            StWrite: state_d = (cnt_q == CntOne) ? StDone : StRead;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pointers wrap naturally at ADDR_W bits.
    always_comb begin
        src_d = src_q;
        dst_d = dst_q;
        cnt_d = cnt_q;
        if (state_q == StIdle && bus.start_v) begin
            src_d = bus.src;
            dst_d = bus.dst;
            cnt_d = bus.len;
        end else if (state_q == StWrite) begin
            src_d = src_q + PtrOne;
            dst_d = dst_q + PtrOne;
            cnt_d = cnt_q - CntOne;
        end
    end

    always_comb begin
        bus.start_ready = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.mem_v       = 1'b0;
        bus.mem_w       = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        unique case (state_q)
            StIdle:  bus.start_ready = 1'b1;
            StRead: begin
                bus.busy     = 1'b1;
                bus.mem_v    = 1'b1;
                bus.mem_addr = src_q;
            end
            StWrite: begin
                bus.busy      = 1'b1;
                bus.mem_v     = 1'b1;
                bus.mem_w     = 1'b1;
                bus.mem_addr  = dst_q;
                bus.mem_wdata = bus.mem_rdata;
            end
            StDone:  bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a forward-copy reference model predicts every
// memory access, its cycle and the done pulse; a monitor checks them as they appear.
module tb_mem_copy_engine;
    localparam int DW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        int kind;  // 0 read, 1 write, 2 done
        int addr;
        int data;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mem_copy_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_copy_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    logic [DW-1:0] mem[DEPTH];
    logic [DW-1:0] init_mem[DEPTH];
    int            ref_mem[DEPTH];
    logic          load = 1'b0;
    logic          mon_en = 1'b0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    ev_t           exp_q[$];
    ev_t           e;

    // 1RW memory, one-cycle read latency; 'load' bulk-initialises it from init_mem.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_mem[i];
        end else if (bus.mem_v) begin
            if (bus.mem_w) mem[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_v || bus.done) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got v=%0d w=%0d addr=%0d done=%0d, expected none",
                             bus.mem_v, bus.mem_w, bus.mem_addr, bus.done);
                end else begin
                    e = exp_q.pop_front();
                    check("kind", bus.done ? 2 : (bus.mem_w ? 1 : 0), e.kind);
                    check("addr", int'(bus.mem_addr), e.addr);
                    if (e.kind == 1) check("wdata", int'(bus.mem_wdata), e.data);
                    check("event_cycle", cyc, e.cyc);
                    check("busy", int'(bus.busy), (e.kind < 2) ? 1 : 0);
                end
            end else if (bus.busy || bus.mem_w) begin
                fail("idle_outputs_active");
            end
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                fail("missed_event");
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic push_ev(input int k, input int a, input int d, input int c);
        ev_t x;
        x.kind = k;
        x.addr = a;
        x.data = d;
        x.cyc  = c;
        exp_q.push_back(x);
    endtask

    task automatic load_mem();
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) init_mem[i] = ref_mem[i][DW-1:0];
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    // Waits for the engine to be ready, presents a request and models it as a forward copy.
    task automatic issue(input int s, input int d, input int l, input bit hold);
        int waited = 0;
        int base;
        int a;
        int v;
        @(negedge clk);
        while (!bus.start_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.start_ready) begin
            fail("ready_timeout");
            return;
        end
        bus.src     = 4'(s);
        bus.dst     = 4'(d);
        bus.len     = 5'(l);
        bus.start_v = 1'b1;
        base = cyc;
        for (int i = 0; i < l; i++) begin
            a = (s + i) % DEPTH;
            v = ref_mem[a];
            push_ev(0, a, 0, base + 2 * i + 1);
            push_ev(1, (d + i) % DEPTH, v, base + 2 * i + 2);
            ref_mem[(d + i) % DEPTH] = v;
        end
        push_ev(2, 0, 0, base + 2 * l + 1);
        @(posedge clk);
        #1;
        if (!hold) bus.start_v = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) fail("drain_timeout");
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.start_v = 1'b0;
        bus.src     = '0;
        bus.dst     = '0;
        bus.len     = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = int'($urandom_range(0, 15));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_start_ready", int'(bus.start_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_mem_v", int'(bus.mem_v), 0);
        check("rst_mem_w", int'(bus.mem_w), 0);
        check("rst_mem_addr", int'(bus.mem_addr), 0);
        check("rst_mem_wdata", int'(bus.mem_wdata), 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Basic two-word copy.
        ref_mem[2] = 5;
        ref_mem[3] = 10;
        load_mem();
        issue(2, 8, 2, 1'b0);
        drain();
        check("copy_mem8", int'(mem[8]), 5);
        check("copy_mem9", int'(mem[9]), 10);

        // Zero length: only a done pulse.
        issue(1, 4, 0, 1'b0);
        drain();

        // Address wrap on both pointers.
        ref_mem[15] = 1;
        ref_mem[0]  = 2;
        ref_mem[1]  = 3;
        load_mem();
        issue(15, 14, 3, 1'b0);
        drain();
        check("wrap_mem14", int'(mem[14]), 1);
        check("wrap_mem15", int'(mem[15]), 2);
        check("wrap_mem0", int'(mem[0]), 3);

        // Overlapping forward copy replicates the first word.
        ref_mem[0] = 7;
        load_mem();
        issue(0, 1, 3, 1'b0);
        drain();
        check("ovl_mem1", int'(mem[1]), 7);
        check("ovl_mem2", int'(mem[2]), 7);
        check("ovl_mem3", int'(mem[3]), 7);

        // start_v held high across a copy.
        issue(3, 10, 2, 1'b1);
        issue(5, 12, 2, 1'b0);
        drain();

        // Reset during the first word's WRITE: that write lands, nothing after it.
        @(negedge clk);
        bus.src     = 4'd4;
        bus.dst     = 4'd11;
        bus.len     = 5'd4;
        bus.start_v = 1'b1;
        push_ev(0, 4, 0, cyc + 1);
        push_ev(1, 11, ref_mem[4], cyc + 2);
        ref_mem[11] = ref_mem[4];
        @(posedge clk);
        #1 bus.start_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_mem_v", int'(bus.mem_v), 0);
        check("abort_start_ready", int'(bus.start_ready), 1);
        check("abort_busy", int'(bus.busy), 0);
        reset_n = 1'b1;
        drain();

        // Randomized requests, including full-memory copies.
        for (int n = 0; n < 24; n++) begin
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 16)), ($urandom_range(0, 2) == 0) && (n != 23));
        end
        bus.start_v = 1'b0;
        issue(6, 6, 16, 1'b0);
        drain();

        for (int i = 0; i < DEPTH; i++) check("final_mem", int'(mem[i]), ref_mem[i]);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
